// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the register-file write-back arbiter.
// The entry struct is sized from these constants, so the top's parameters must keep these values.
package wb_arb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_REG_W  = 5;
  localparam int WB_DEPTH  = 2;
  localparam int SEQ_W     = $clog2(2 * WB_DEPTH) + 1;

  typedef struct packed {
    logic [WB_REG_W-1:0]  rd;
    logic [WB_DATA_W-1:0] data;
    logic [SEQ_W-1:0]     seq;
  } wb_entry_t;

  // The tag window is less than half the tag space, so a negative wrapped difference means "older".
  function automatic logic older(input logic [SEQ_W-1:0] a, input logic [SEQ_W-1:0] b);
    logic [SEQ_W-1:0] diff;
    diff = a - b;
    return diff[SEQ_W-1];
  endfunction

endpackage

// File: rtl/wb_lane_fifo.sv
// Per-lane write-back queue: small synchronous FIFO of wb_entry_t with flush.
// The caller must not push when full or pop when empty.
module wb_lane_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return {AW{1'b0}};
    end else begin
      return p + AW'(1);
    end
  endfunction

  // Pointer and occupancy state; flush behaves like a reset of the queue.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= {AW{1'b0}};
      wr_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage array; contents are irrelevant while the queue is empty.
  always_ff @(posedge clk) begin
    if (push && rst && !flush) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == {CW{1'b0}});

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between two lanes, committing one write
// per cycle in global issue order and pulsing a per-lane ack on each retirement.
module regfile_wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int REG_W  = WB_REG_W,
  parameter int DEPTH  = WB_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wb1_valid,
  output logic              wb1_ready,
  input  logic [REG_W-1:0]  wb1_rd,
  input  logic [DATA_W-1:0] wb1_data,
  input  logic              wb2_valid,
  output logic              wb2_ready,
  input  logic [REG_W-1:0]  wb2_rd,
  input  logic [DATA_W-1:0] wb2_data,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              ack1,
  output logic              ack2,
  output logic              pending
);

  logic [SEQ_W-1:0] seq_cnt;
  wb_entry_t        in1, in2, head1, head2, sel;
  logic             full1, full2, empty1, empty2;
  logic             push1, push2, grant1, grant2;

  assign wb1_ready = !full1 && !flush && rst;
  assign wb2_ready = !full2 && !flush && rst;
  assign push1     = wb1_valid && wb1_ready;
  assign push2     = wb2_valid && wb2_ready;

  // Lane 1 is treated as the older of two simultaneous results.
  assign in1 = '{rd: wb1_rd, data: wb1_data, seq: seq_cnt};
  assign in2 = '{rd: wb2_rd, data: wb2_data, seq: (push1 ? seq_cnt + SEQ_W'(1) : seq_cnt)};

  // Issue-order tag counter.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      seq_cnt <= {SEQ_W{1'b0}};
    end else begin
      seq_cnt <= seq_cnt + SEQ_W'(push1) + SEQ_W'(push2);
    end
  end

  wb_lane_fifo #(.DEPTH(DEPTH)) u_lane1 (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (push1),
    .push_entry (in1),
    .pop        (grant1),
    .head       (head1),
    .full       (full1),
    .empty      (empty1)
  );

  wb_lane_fifo #(.DEPTH(DEPTH)) u_lane2 (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (push2),
    .push_entry (in2),
    .pop        (grant2),
    .head       (head2),
    .full       (full2),
    .empty      (empty2)
  );

  // Grant the older valid head; nothing is popped during reset or flush.
  always_comb begin
    grant1 = 1'b0;
    grant2 = 1'b0;
    if (!rst || flush) begin
      grant1 = 1'b0;
      grant2 = 1'b0;
    end else if (!empty1 && !empty2) begin
      if (older(head1.seq, head2.seq)) begin
        grant1 = 1'b1;
      end else begin
        grant2 = 1'b1;
      end
    end else if (!empty1) begin
      grant1 = 1'b1;
    end else if (!empty2) begin
      grant2 = 1'b1;
    end else begin
      grant1 = 1'b0;
      grant2 = 1'b0;
    end
  end

  assign sel = grant1 ? head1 : head2;

  // Registered commit stage; address and data hold their last values when idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= {REG_W{1'b0}};
      rf_wdata <= {DATA_W{1'b0}};
      ack1     <= 1'b0;
      ack2     <= 1'b0;
    end else if (flush) begin
      rf_we <= 1'b0;
      ack1  <= 1'b0;
      ack2  <= 1'b0;
    end else begin
      rf_we <= (grant1 || grant2) && (sel.rd != {REG_W{1'b0}});
      ack1  <= grant1;
      ack2  <= grant2;
      if (grant1 || grant2) begin
        rf_waddr <= sel.rd;
        rf_wdata <= sel.data;
      end
    end
  end

  assign pending = !empty1 || !empty2 || ack1 || ack2;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between the two datapath lanes of the dual-issue core.
- Each lane pushes completed results (rd, data) through a valid/ready handshake into a small per-lane queue.
- The arbiter commits one write per cycle in strict global issue order, so same-register writes from the two lanes never reorder.
- It pulses per-lane acks that the scheduling logic uses to release dependency stalls.

Parameters:
- DATA_W, 32, register data width.
- REG_W, 5, register index width.
- DEPTH, 2, entries per lane queue (power of two, ≥1).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-low (asserted at 0)
- flush  in  1  drop all queued writes (pipeline redirect)
- wb1_valid  in  1  lane 1 result valid
- wb1_ready  out  1  lane 1 queue can accept
- wb1_rd  in  REG_W  lane 1 destination
- wb1_data  in  DATA_W  lane 1 result
- wb2_valid / wb2_ready / wb2_rd / wb2_data  same as lane 1, for lane 2
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_W  write address
- rf_wdata  out  DATA_W  write data
- ack1  out  1  one-cycle pulse: a lane 1 entry retired
- ack2  out  1  one-cycle pulse: a lane 2 entry retired
- pending  out  1  any entry queued or in output stage

Behaviour:
- Reset (rst==0 at a rising edge):
  - Queues are emptied and the sequence counter is cleared to 0.
  - rf_we, rf_waddr, rf_wdata, ack1, ack2 and pending are all 0.
  - wb1_ready and wb2_ready are forced to 0 while rst==0.
  - Reset mid-operation discards all entries with no acks.
- Handshake:
  - A transfer occurs when wbN_valid && wbN_ready at a rising edge.
  - wbN_ready = !full_N && !flush && rst.
  - No same-cycle bypass: ready depends on the current occupancy only, not on a dequeue in the same cycle.
- Sequence tags:
  - SEQ_W = $clog2(2*DEPTH)+1.
  - Each accepted entry takes the tag seq_cnt; seq_cnt advances by the number of entries accepted that cycle (0, 1 or 2, modulo 2^SEQ_W).
  - On simultaneous accept, lane 1 takes seq_cnt and lane 2 takes seq_cnt+1, so lane 1 is older.
- Arbitration (combinational, on queue heads):
  - If only one head is valid, grant it.
  - If both are valid, grant the older one: A is older than B iff the MSB of (tagA − tagB) mod 2^SEQ_W is 1.
  - Exactly one pop per cycle at most.
- Output stage (registered): the granted head pops at edge E. In the cycle after E:
  - rf_waddr and rf_wdata carry the entry.
  - rf_we = (rd != 0).
  - ackN = 1 for the granted lane. This applies to x0 writes too: acked but not written.
- Latency: accepted at edge E0 → earliest rf_we/ack in the cycle after edge E0+1 (2 cycles). Throughput is 1 write/cycle total.
- Full queue: ready is low and the entry is held upstream. Full and pop in the same cycle still drops ready for that cycle.
- Flush (synchronous, priority below reset):
  - Empties both queues and clears seq_cnt.
  - Forces rf_we=0 and ack=0 on the next cycle; no entry popped in the flush cycle commits.
  - Inputs are not accepted during the flush cycle.
- pending = any queue non-empty || the output stage holds a valid entry.
- Idle: rf_waddr and rf_wdata hold their last values; rf_we=0.

Decomposition:
- Package wb_arb_pkg:
  - localparam SEQ_W.
  - typedef wb_entry_t struct {rd[REG_W], data[DATA_W], seq[SEQ_W]}.
  - function older(a,b).
- Sub-module wb_lane_fifo:
  - DEPTH-entry synchronous FIFO of wb_entry_t.
  - Interface: push, pop, head, full, empty, flush.
  - Instantiated twice.

Test Plan:
- Single write: wb1 {rd=5, data=0xDEADBEEF} accepted at cycle 1 → cycle 3: rf_we=1, waddr=5, wdata=0xDEADBEEF, ack1=1, ack2=0; pending is 0 from cycle 4.
- Simultaneous same-rd: wb1 {rd=7, 0x11} and wb2 {rd=7, 0x22} in the same cycle → lane 1 commits 0x11 first, lane 2 commits 0x22 the next cycle; final x7=0x22; ack1 then ack2.
- Back-pressure: hold wb2_valid with DEPTH=2 and no pops possible (lane 1 older entries queued) → wb2_ready drops after 2 accepts; no data lost; 4 commits in tag order.
- x0 write: wb2 {rd=0, 0x55} → ack2 pulses with rf_we=0.
- Flush: queue 3 entries, assert flush for 1 cycle → no rf_we and no acks afterward; ready low during the flush cycle; new entry accepted next cycle commits 2 cycles later.
- Tag wraparound: stream 40 alternating writes from both lanes with random valid → commit order matches acceptance order exactly across seq wrap; reset asserted mid-stream clears all outputs to 0 on the next edge.
